pwm_capture: RTL

Measures the duty cycle of an incoming PWM waveform and recovers the level value that produced it. It is the receive-side counterpart of the team's fixed-period PWM generator, which outputs high for `level` of every 2^LEVEL_WIDTH cycles. It sits behind a pin or loopback path and reports one registered level sample per PWM period. It also flags a wrong period, a line stuck low and a line stuck high.

---
 rtl/pwm_capture.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// pwm_capture
// -----------
// Receive-side decoder for a fixed-period PWM waveform. Recovers the level
// value (number of high cycles per 2^LEVEL_WIDTH-cycle period) of the
// generator that drove pwm_in. Reports one registered sample per period and
// flags wrong periods and lines stuck low or high.
//
// Parameters
//   LEVEL_WIDTH    width of the recovered level; nominal period P_NOM = 2^LEVEL_WIDTH
//   INVERTED_INPUT invert pwm_in after synchronisation (inverted-output generator)
//   SYNC_STAGES    synchroniser depth on pwm_in (>= 2)
//
// Ports
//   clk         clock, all logic on the rising edge
//   reset       synchronous, active-high
//   pwm_in      PWM input, asynchronous to clk
//   level       last recovered level, held between updates
//   valid       one-cycle pulse, level/period_err updated in the same cycle
//   locked      high while the last measured period equalled P_NOM
//   period_err  registered with each valid; high if the period differed from P_NOM
//   stuck_high  high while the line is idle at the high level
module pwm_capture #(
    parameter int unsigned LEVEL_WIDTH    = 8,
    parameter bit          INVERTED_INPUT = 1'b0,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pwm_in,
    output logic [LEVEL_WIDTH-1:0] level,
    output logic                   valid,
    output logic                   locked,
    output logic                   period_err,
    output logic                   stuck_high
);

    localparam int unsigned PW = LEVEL_WIDTH + 2;   // period counter width
    localparam int unsigned HW = LEVEL_WIDTH + 1;   // high counter width
    localparam int unsigned WW = $clog2(SYNC_STAGES + 2);

    localparam logic [PW-1:0] P_ONE   = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] P_NOM   = P_ONE << LEVEL_WIDTH;
    localparam logic [PW-1:0] TIMEOUT = P_ONE << (LEVEL_WIDTH + 1);
    localparam logic [HW-1:0] H_ONE   = {{(HW-1){1'b0}}, 1'b1};
    localparam logic [HW-1:0] H_MAX   = {HW{1'b1}};
    localparam logic [LEVEL_WIDTH-1:0] LEVEL_MAX = {LEVEL_WIDTH{1'b1}};

    // Warm-up milestones after reset release: counting starts once the
    // synchroniser has flushed its reset zeros, edge detection one cycle
    // later once s_d_reg also holds a genuine sample.
    localparam logic [WW-1:0] WARM_COUNT = WW'(SYNC_STAGES);
    localparam logic [WW-1:0] WARM_EDGE  = WW'(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        IDLE_LOW,
        IDLE_HIGH
    } state_t;

    state_t                 state_reg;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   s;
    logic                   s_d_reg;
    logic                   rise;
    logic [WW-1:0]          warm_reg;
    logic                   count_en;
    logic                   edge_en;
    logic [PW-1:0]          period_cnt_reg;
    logic [HW-1:0]          high_cnt_reg;
    logic [LEVEL_WIDTH-1:0] high_level;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg <= '0;
            s_d_reg  <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], pwm_in};
            s_d_reg  <= s;
        end
    end

    assign s = sync_reg[SYNC_STAGES-1] ^ INVERTED_INPUT;

    // While the synchroniser still holds reset zeros, s can show a transition
    // that never happened on the pin (e.g. a line held high through reset, or
    // the inverted decode). Such a fake rise would start a bogus measurement,
    // so edges are ignored until the pipeline carries real samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            warm_reg <= '0;
        end else if (warm_reg != WARM_EDGE) begin
            warm_reg <= warm_reg + 1'b1;
        end
    end

    assign count_en = (warm_reg >= WARM_COUNT);
    assign edge_en  = (warm_reg == WARM_EDGE);
    assign rise     = s & ~s_d_reg & edge_en;

    // A high count of P_NOM or more only occurs on an over-long interval;
    // report it as all-ones rather than letting it wrap.
    assign high_level = high_cnt_reg[LEVEL_WIDTH] ? LEVEL_MAX
                                                  : high_cnt_reg[LEVEL_WIDTH-1:0];

    // ------------------------------------------------------------------
    // Measurement state machine, all outputs registered
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= SEARCH;
            period_cnt_reg <= '0;
            high_cnt_reg   <= '0;
            level          <= '0;
            valid          <= 1'b0;
            locked         <= 1'b0;
            period_err     <= 1'b0;
            stuck_high     <= 1'b0;
        end else begin
            valid <= 1'b0;

            case (state_reg)
                SEARCH, MEASURE: begin
                    if (!count_en) begin
                        // synchroniser still flushing; hold everything
                    end else if (rise) begin
                        // A rise always wins over a coincident timeout. The
                        // interval closed by the first rise out of SEARCH is
                        // partial, so only MEASURE reports.
                        if (state_reg == MEASURE) begin
                            valid      <= 1'b1;
                            level      <= high_level;
                            period_err <= (period_cnt_reg != P_NOM);
                            locked     <= (period_cnt_reg == P_NOM);
                        end
                        period_cnt_reg <= P_ONE;
                        high_cnt_reg   <= H_ONE;
                        state_reg      <= MEASURE;
                    end else if (period_cnt_reg == TIMEOUT) begin
                        // No rise for two nominal periods: the line is stuck
                        // at its current level. Report it immediately; the
                        // idle state repeats the report every P_NOM cycles.
                        state_reg      <= s ? IDLE_HIGH : IDLE_LOW;
                        valid          <= 1'b1;
                        level          <= s ? LEVEL_MAX : '0;
                        period_err     <= 1'b1;
                        locked         <= 1'b0;
                        stuck_high     <= s;
                        period_cnt_reg <= P_ONE;
                        high_cnt_reg   <= '0;
                    end else begin
                        period_cnt_reg <= period_cnt_reg + 1'b1;
                        if (state_reg == MEASURE && s && high_cnt_reg != H_MAX) begin
                            high_cnt_reg <= high_cnt_reg + 1'b1;
                        end
                    end
                end

                IDLE_LOW, IDLE_HIGH: begin
                    // period_cnt_reg doubles as the idle report interval timer.
                    if (rise) begin
                        state_reg      <= MEASURE;
                        period_cnt_reg <= P_ONE;
                        high_cnt_reg   <= H_ONE;
                        stuck_high     <= 1'b0;
                    end else if (period_cnt_reg == P_NOM) begin
                        valid          <= 1'b1;
                        level          <= (state_reg == IDLE_HIGH) ? LEVEL_MAX : '0;
                        period_err     <= 1'b1;
                        locked         <= 1'b0;
                        period_cnt_reg <= P_ONE;
                    end else begin
                        period_cnt_reg <= period_cnt_reg + 1'b1;
                    end
                end

                default: begin
                    state_reg <= SEARCH;
                end
            endcase
        end
    end

endmodule
